// File: rtl/mem_mshr.sv
// Miss status holding registers: track outstanding DCache read misses, issue block reads, fill and wake LQ waiters.
// Optional MSHR_MERGE_EN: a miss to a block already outstanding joins that entry's waiters instead of allocating.
module mem_mshr #(
   parameter int LSQSZ  = 8,
   parameter int MSHRSZ = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             except,
   input  logic             miss_valid,
   input  logic [15:0]      miss_addr,
   input  logic [LSQSZ-1:0] miss_gnt,
   output logic             mshr_full,
   output logic             mem_req_valid,
   output logic [15:0]      mem_req_addr,
   input  logic [3:0]       mem_resp_ack,
   input  logic [3:0]       mem_resp_tag,
   input  logic [63:0]      mem_resp_data,
   output logic [LSQSZ-1:0] mem_feedback,
   output logic [31:0]      mem_data,
   output logic             fill_en,
   output logic [7:0]       fill_tag,
   output logic [4:0]       fill_idx,
   output logic [63:0]      fill_data
);

   localparam int IW = $clog2(MSHRSZ);

   typedef enum logic [1:0] {INVALID, PENDING, WAIT} entry_state_t;

   entry_state_t     state        [MSHRSZ];
   entry_state_t     state_next   [MSHRSZ];
   logic [13:0]      addr         [MSHRSZ];
   logic [13:0]      addr_next    [MSHRSZ];
   logic [3:0]       tag          [MSHRSZ];
   logic [3:0]       tag_next     [MSHRSZ];
   logic [LSQSZ-1:0] waiters      [MSHRSZ];
   logic [LSQSZ-1:0] waiters_next [MSHRSZ];
   logic             orphan       [MSHRSZ];
   logic             orphan_next  [MSHRSZ];

   logic          free_found, req_found, done_found, merge_found;
   logic [IW-1:0] free_idx, req_idx, done_idx, merge_idx;
   logic          unused_offset;

   assign unused_offset = ^miss_addr[1:0];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < MSHRSZ; i++) begin
            state[i]   <= INVALID;
            addr[i]    <= '0;
            tag[i]     <= '0;
            waiters[i] <= '0;
            orphan[i]  <= 1'b0;
         end
      end else begin
         for (int i = 0; i < MSHRSZ; i++) begin
            state[i]   <= state_next[i];
            addr[i]    <= addr_next[i];
            tag[i]     <= tag_next[i];
            waiters[i] <= waiters_next[i];
            orphan[i]  <= orphan_next[i];
         end
      end
   end

   // Descending scans so the lowest matching index wins.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      req_found  = 1'b0;
      req_idx    = '0;
      done_found = 1'b0;
      done_idx   = '0;
      for (int i = MSHRSZ - 1; i >= 0; i--) begin
         if (state[i] == INVALID) begin
            free_found = 1'b1;
            free_idx   = IW'(i);
         end
         if (state[i] == PENDING) begin
            req_found = 1'b1;
            req_idx   = IW'(i);
         end
         if (state[i] == WAIT && mem_resp_tag != 4'd0 && tag[i] == mem_resp_tag) begin
            done_found = 1'b1;
            done_idx   = IW'(i);
         end
      end
   end

`ifdef MSHR_MERGE_EN
   // An entry completing this cycle is about to vanish, so it cannot take new waiters.
   always_comb begin
      merge_found = 1'b0;
      merge_idx   = '0;
      for (int i = MSHRSZ - 1; i >= 0; i--) begin
         if (state[i] != INVALID && !orphan[i] && addr[i] == miss_addr[15:2] &&
             !(done_found && done_idx == IW'(i))) begin
            merge_found = 1'b1;
            merge_idx   = IW'(i);
         end
      end
   end
`else
   assign merge_found = 1'b0;
   assign merge_idx   = '0;
`endif

   always_comb begin
      for (int i = 0; i < MSHRSZ; i++) begin
         state_next[i]   = state[i];
         addr_next[i]    = addr[i];
         tag_next[i]     = tag[i];
         waiters_next[i] = waiters[i];
         orphan_next[i]  = orphan[i];
      end
      if (done_found) begin
         state_next[done_idx]   = INVALID;
         waiters_next[done_idx] = '0;
      end
      if (req_found && mem_resp_ack != 4'd0) begin
         state_next[req_idx] = WAIT;
         tag_next[req_idx]   = mem_resp_ack;
      end
      // Flush: unissued work is discarded, in-flight reads still fill but wake nobody.
      if (except) begin
         for (int i = 0; i < MSHRSZ; i++) begin
            if (state[i] == PENDING) begin
               state_next[i] = INVALID;
            end else if (state[i] == WAIT) begin
               orphan_next[i]  = 1'b1;
               waiters_next[i] = '0;
            end
         end
      end else if (miss_valid) begin
         if (merge_found) begin
            waiters_next[merge_idx] = waiters[merge_idx] | miss_gnt;
         end else if (free_found) begin
            state_next[free_idx]   = PENDING;
            addr_next[free_idx]    = miss_addr[15:2];
            tag_next[free_idx]     = '0;
            waiters_next[free_idx] = miss_gnt;
            orphan_next[free_idx]  = 1'b0;
         end
      end
   end

   assign mshr_full = !free_found;

   always_comb begin
      mem_req_valid = req_found;
      mem_req_addr  = '0;
      fill_en       = 1'b0;
      fill_tag      = '0;
      fill_idx      = '0;
      fill_data     = '0;
      mem_feedback  = '0;
      mem_data      = '0;
      if (req_found) begin
         mem_req_addr = {addr[req_idx][13:1], 3'b000};
      end
      if (done_found) begin
         fill_en      = 1'b1;
         fill_tag     = addr[done_idx][13:6];
         fill_idx     = addr[done_idx][5:1];
         fill_data    = mem_resp_data;
         mem_feedback = orphan[done_idx] ? '0 : waiters[done_idx];
         mem_data     = addr[done_idx][0] ? mem_resp_data[63:32] : mem_resp_data[31:0];
      end
   end

endmodule
